// File: rtl/ts_mux_scheduler.sv
// ts_mux_scheduler
// Packet-aligned round-robin scheduler for the four-channel TS output mux.
// It selects a channel only on that channel's sync byte. It then holds the
// selection for exactly PKT_LEN valid bytes, so the FIFO write side only
// ever sees whole transport packets that each start with a sync byte.
//
// Optional feature macro: TS_SCHED_TIMEOUT_EN
//   When defined, a packet whose channel stalls for TIMEOUT cycles is
//   aborted and timeout_err pulses. When undefined, timeout_err is tied to 0.
//
// Ports:
//   clk2        in   write-side clock (rising edge)
//   rstn        in   asynchronous active-low reset
//   valid_in    in   [3:0] per-channel byte valid
//   sync_in     in   [3:0] per-channel sync flag (qualified by valid_in)
//   ch_enable   in   [3:0] channel enable, sampled at arbitration only
//   mux_ctrl    out  [1:0] channel select (Mealy in IDLE)
//   gate_valid  out  valid gate for the FIFO write (Mealy)
//   pkt_done    out  one-cycle pulse after the final byte of a packet
//   sync_err    out  one-cycle pulse after an early sync byte
//   timeout_err out  one-cycle pulse after a stalled packet is aborted
//   pkt_cnt     out  [15:0] completed packet count, wraps
module ts_mux_scheduler #(
    parameter int PKT_LEN = 188,
    parameter int CNT_W   = 8,
    parameter int TIMEOUT = 1024
) (
    input  logic        clk2,
    input  logic        rstn,
    input  logic [3:0]  valid_in,
    input  logic [3:0]  sync_in,
    input  logic [3:0]  ch_enable,
    output logic [1:0]  mux_ctrl,
    output logic        gate_valid,
    output logic        pkt_done,
    output logic        sync_err,
    output logic        timeout_err,
    output logic [15:0] pkt_cnt
);

    localparam logic [0:0] ST_IDLE   = 1'b0;
    localparam logic [0:0] ST_PACKET = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [1:0]       last_q, last_d;
    logic [CNT_W-1:0] byte_cnt_q, byte_cnt_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             done_q, done_d;
    logic             serr_q, serr_d;
    logic             tout_q, tout_d;

`ifdef TS_SCHED_TIMEOUT_EN
    localparam int STALL_W = $clog2(TIMEOUT + 1);
    logic [STALL_W-1:0] stall_q, stall_d;
`endif

    logic [3:0] req_s;
    logic [1:0] grant_s;
    logic       any_req_s;
    logic [1:0] arb_idx_s;
    logic [1:0] mux_s;
    logic       gate_s;

    assign req_s = ch_enable & valid_in & sync_in;

    // Round-robin search starting one past the last served channel.
    always_comb begin
        grant_s   = 2'd0;
        any_req_s = 1'b0;
        arb_idx_s = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            arb_idx_s = last_q + 2'(k);
            if (!any_req_s && req_s[arb_idx_s]) begin
                grant_s   = arb_idx_s;
                any_req_s = 1'b1;
            end else begin
                any_req_s = any_req_s;
            end
        end
    end

    // Next-state logic and Mealy mux/gate outputs.
    always_comb begin
        state_d    = state_q;
        sel_d      = sel_q;
        last_d     = last_q;
        byte_cnt_d = byte_cnt_q;
        pkt_cnt_d  = pkt_cnt_q;
        done_d     = 1'b0;
        serr_d     = 1'b0;
        tout_d     = 1'b0;
        mux_s      = sel_q;
        gate_s     = 1'b0;
`ifdef TS_SCHED_TIMEOUT_EN
        stall_d    = stall_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (any_req_s) begin
                    // The sync byte itself is forwarded in the grant cycle.
                    mux_s      = grant_s;
                    gate_s     = 1'b1;
                    sel_d      = grant_s;
                    byte_cnt_d = CNT_W'(1);
                    state_d    = ST_PACKET;
`ifdef TS_SCHED_TIMEOUT_EN
                    stall_d    = '0;
`endif
                end else begin
                    mux_s  = sel_q;
                    gate_s = 1'b0;
                end
            end
            ST_PACKET: begin
                mux_s  = sel_q;
                gate_s = valid_in[sel_q];
                if (valid_in[sel_q]) begin
`ifdef TS_SCHED_TIMEOUT_EN
                    stall_d = '0;
`endif
                    // A sync byte wins over a final byte: restart the count.
                    if (sync_in[sel_q]) begin
                        byte_cnt_d = CNT_W'(1);
                        serr_d     = 1'b1;
                    end else if (byte_cnt_q == CNT_W'(PKT_LEN - 1)) begin
                        state_d    = ST_IDLE;
                        last_d     = sel_q;
                        pkt_cnt_d  = pkt_cnt_q + 16'd1;
                        done_d     = 1'b1;
                        byte_cnt_d = '0;
                    end else begin
                        byte_cnt_d = byte_cnt_q + CNT_W'(1);
                    end
                end else begin
`ifdef TS_SCHED_TIMEOUT_EN
                    stall_d = stall_q + STALL_W'(1);
                    if (stall_d == STALL_W'(TIMEOUT)) begin
                        state_d = ST_IDLE;
                        last_d  = sel_q;
                        tout_d  = 1'b1;
                        stall_d = '0;
                    end else begin
                        tout_d  = 1'b0;
                    end
`else
                    tout_d = 1'b0;
`endif
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and pulse registers.
    always_ff @(posedge clk2 or negedge rstn) begin
        if (!rstn) begin
            state_q    <= ST_IDLE;
            sel_q      <= 2'd0;
            last_q     <= 2'd3;
            byte_cnt_q <= '0;
            pkt_cnt_q  <= 16'd0;
            done_q     <= 1'b0;
            serr_q     <= 1'b0;
            tout_q     <= 1'b0;
`ifdef TS_SCHED_TIMEOUT_EN
            stall_q    <= '0;
`endif
        end else begin
            state_q    <= state_d;
            sel_q      <= sel_d;
            last_q     <= last_d;
            byte_cnt_q <= byte_cnt_d;
            pkt_cnt_q  <= pkt_cnt_d;
            done_q     <= done_d;
            serr_q     <= serr_d;
            tout_q     <= tout_d;
`ifdef TS_SCHED_TIMEOUT_EN
            stall_q    <= stall_d;
`endif
        end
    end

    // The Mealy outputs are forced low while reset is held, even with traffic present.
    assign mux_ctrl    = rstn ? mux_s : 2'd0;
    assign gate_valid  = rstn & gate_s;
    assign pkt_done    = done_q;
    assign sync_err    = serr_q;
    assign timeout_err = tout_q;
    assign pkt_cnt     = pkt_cnt_q;

endmodule

// File: tb/tb_ts_mux_scheduler.sv
// Directed testbench for ts_mux_scheduler. Inputs change 1 time unit after
// the rising edge, and outputs are sampled 4 time units later, mid-cycle.
module tb_ts_mux_scheduler;

    localparam int PKT = 188;

    logic        clk2 = 1'b0;
    logic        rstn;
    logic [3:0]  valid_in;
    logic [3:0]  sync_in;
    logic [3:0]  ch_enable;
    logic [1:0]  mux_ctrl;
    logic        gate_valid;
    logic        pkt_done;
    logic        sync_err;
    logic        timeout_err;
    logic [15:0] pkt_cnt;

    int n_cmp = 0;
    int n_err = 0;
    logic start_done;

    ts_mux_scheduler dut (
        .clk2       (clk2),
        .rstn       (rstn),
        .valid_in   (valid_in),
        .sync_in    (sync_in),
        .ch_enable  (ch_enable),
        .mux_ctrl   (mux_ctrl),
        .gate_valid (gate_valid),
        .pkt_done   (pkt_done),
        .sync_err   (sync_err),
        .timeout_err(timeout_err),
        .pkt_cnt    (pkt_cnt)
    );

    always #5 clk2 = ~clk2;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk2);
        #1;
    endtask

    // Drive one packet on channel ch. Other channels carry valid-only noise.
    // gap_len idle cycles are inserted after byte gap_after. A second sync
    // is inserted at byte esync_at when it is >= 0. all_sync raises sync on
    // all four channels in the first cycle so that arbitration must choose.
    task automatic run_pkt(input string tag, input int ch, input int gap_after,
                           input int gap_len, input int esync_at, input logic all_sync);
        int nb;
        int bad;
        int done_n;
        logic [3:0] bit_m;
        bit_m  = 4'b0001 << ch;
        nb     = (esync_at >= 0) ? esync_at + PKT : PKT;
        bad    = 0;
        done_n = 0;
        for (int b = 0; b < nb; b++) begin
            if (gap_len > 0 && b == gap_after + 1) begin
                for (int g = 0; g < gap_len; g++) begin
                    valid_in = ~bit_m;
                    sync_in  = 4'b0000;
                    #4;
                    if (gate_valid !== 1'b0 || mux_ctrl !== 2'(ch)) bad++;
                    if (pkt_done === 1'b1) done_n++;
                    next_cycle();
                end
            end
            valid_in = 4'b1111;
            if (b == 0) sync_in = all_sync ? 4'b1111 : bit_m;
            else if (b == esync_at) sync_in = bit_m;
            else sync_in = 4'b0000;
            #4;
            if (b == 0) begin
                start_done = pkt_done;
            end else begin
                if (pkt_done === 1'b1) done_n++;
                if (sync_err !== ((esync_at >= 0) && (b == esync_at + 1))) bad++;
            end
            if (mux_ctrl !== 2'(ch) || gate_valid !== 1'b1) bad++;
            next_cycle();
        end
        check_eq({tag, "_mux_gate"}, 32'(bad), 32'd0);
        check_eq({tag, "_no_early_done"}, 32'(done_n), 32'd0);
    endtask

    // Idle cycle after a packet: pkt_done must pulse and the count must advance.
    task automatic idle_after(input string tag, input logic [1:0] exp_mux, input logic [15:0] exp_cnt);
        valid_in = 4'b0000;
        sync_in  = 4'b0000;
        #4;
        check_eq({tag, "_pkt_done"}, 32'(pkt_done), 32'd1);
        check_eq({tag, "_pkt_cnt"}, 32'(pkt_cnt), 32'(exp_cnt));
        check_eq({tag, "_idle_gate"}, 32'(gate_valid), 32'd0);
        check_eq({tag, "_idle_mux"}, 32'(mux_ctrl), 32'(exp_mux));
        next_cycle();
    endtask

    initial begin
        int bad;
        int to_n;
        int dn;

        // Reset held with live traffic: all outputs low immediately.
        rstn      = 1'b0;
        valid_in  = 4'b1111;
        sync_in   = 4'b1111;
        ch_enable = 4'b1111;
        #2;
        check_eq("rst_mux", 32'(mux_ctrl), 32'd0);
        check_eq("rst_gate", 32'(gate_valid), 32'd0);
        check_eq("rst_pulses", 32'({pkt_done, sync_err, timeout_err}), 32'd0);
        check_eq("rst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        next_cycle();
        next_cycle();
        valid_in = 4'b0000;
        sync_in  = 4'b0000;
        rstn     = 1'b1;
        #4;
        check_eq("post_rst_mux", 32'(mux_ctrl), 32'd0);
        check_eq("post_rst_gate", 32'(gate_valid), 32'd0);
        next_cycle();

        // Single ch2 packet; pkt_done follows the 188th byte.
        ch_enable = 4'b0100;
        run_pkt("single", 2, -1, 0, -1, 1'b0);
        idle_after("single", 2'd2, 16'd1);

        // ch1 packet with a 10-cycle gap after byte 50.
        ch_enable = 4'b0010;
        run_pkt("gap", 1, 50, 10, -1, 1'b0);
        idle_after("gap", 2'd1, 16'd2);

        // Early sync on ch3 at byte 100 restarts the count.
        ch_enable = 4'b1000;
        run_pkt("esync", 3, -1, 0, 100, 1'b0);
        idle_after("esync", 2'd3, 16'd3);

        // ch0 stalls after byte 50.
        ch_enable = 4'b0001;
        bad = 0;
        for (int b = 0; b <= 50; b++) begin
            valid_in = 4'b0001;
            sync_in  = (b == 0) ? 4'b0001 : 4'b0000;
            #4;
            if (mux_ctrl !== 2'd0 || gate_valid !== 1'b1) bad++;
            next_cycle();
        end
        to_n = 0;
        for (int s = 0; s < 1100; s++) begin
            valid_in = 4'b1110;
            sync_in  = 4'b0000;
            #4;
            if (gate_valid !== 1'b0 || mux_ctrl !== 2'd0) bad++;
            if (timeout_err === 1'b1) to_n++;
            next_cycle();
        end
        check_eq("stall_mux_gate", 32'(bad), 32'd0);
`ifdef TS_SCHED_TIMEOUT_EN
        check_eq("timeout_pulses", 32'(to_n), 32'd1);
        check_eq("timeout_pkt_cnt", 32'(pkt_cnt), 32'd3);
`else
        check_eq("no_timeout", 32'(to_n), 32'd0);
        // Still in PACKET: the remaining 137 bytes finish the packet.
        bad = 0;
        dn  = 0;
        for (int b = 51; b < PKT; b++) begin
            valid_in = 4'b0001;
            sync_in  = 4'b0000;
            #4;
            if (gate_valid !== 1'b1 || mux_ctrl !== 2'd0) bad++;
            if (pkt_done === 1'b1) dn++;
            next_cycle();
        end
        check_eq("resume_gate", 32'(bad), 32'd0);
        check_eq("resume_no_early_done", 32'(dn), 32'd0);
        idle_after("resume", 2'd0, 16'd4);
`endif

        // Reset asserted in the middle of a ch0 packet.
        for (int b = 0; b < 20; b++) begin
            valid_in = 4'b0001;
            sync_in  = (b == 0) ? 4'b0001 : 4'b0000;
            next_cycle();
        end
        valid_in = 4'b0001;
        sync_in  = 4'b0000;
        #2;
        rstn = 1'b0;
        #1;
        check_eq("midrst_gate", 32'(gate_valid), 32'd0);
        check_eq("midrst_mux", 32'(mux_ctrl), 32'd0);
        check_eq("midrst_pkt_cnt", 32'(pkt_cnt), 32'd0);
        next_cycle();
        valid_in = 4'b0000;
        rstn     = 1'b1;
        #4;
        check_eq("midrst_idle_gate", 32'(gate_valid), 32'd0);
        next_cycle();

        // Round-robin: all channels request on every grant cycle.
        ch_enable = 4'b1111;
        run_pkt("rr0", 0, -1, 0, -1, 1'b1);
        run_pkt("rr1", 1, -1, 0, -1, 1'b1);
        check_eq("rr1_b2b_done", 32'(start_done), 32'd1);
        run_pkt("rr2", 2, -1, 0, -1, 1'b1);
        check_eq("rr2_b2b_done", 32'(start_done), 32'd1);
        run_pkt("rr3", 3, -1, 0, -1, 1'b1);
        check_eq("rr3_b2b_done", 32'(start_done), 32'd1);
        run_pkt("rr4", 0, -1, 0, -1, 1'b1);
        check_eq("rr4_b2b_done", 32'(start_done), 32'd1);
        idle_after("rr", 2'd0, 16'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
